// File: rtl/traffic_pkg.sv
// traffic_pkg: shared phase/light/fault encodings for the traffic light
// controller and its monitor.
//   - phase values (2-bit, same as the controller)
//   - one-hot light codes {R,Y,G}
//   - fault codes reported by traffic_light_monitor
//   - monitor FSM state type and a saturating dwell increment helper
package traffic_pkg;

  localparam logic [1:0] PH_MG_SR = 2'd0;
  localparam logic [1:0] PH_MY_SR = 2'd1;
  localparam logic [1:0] PH_MR_SG = 2'd2;
  localparam logic [1:0] PH_MR_SY = 2'd3;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [2:0] FC_NONE       = 3'd0;
  localparam logic [2:0] FC_ILLEGAL    = 3'd1;
  localparam logic [2:0] FC_TRANSITION = 3'd2;
  localparam logic [2:0] FC_SHORT      = 3'd3;
  localparam logic [2:0] FC_LONG       = 3'd4;

  typedef enum logic {
    ST_ACQUIRE = 1'b0,
    ST_LOCKED  = 1'b1
  } mon_state_e;

  // Dwell counter increment that sticks at the 9-bit maximum.
  function automatic logic [8:0] dwell_inc(input logic [8:0] v);
    if (v == 9'd511) begin
      return v;
    end else begin
      return v + 9'd1;
    end
  endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// traffic_light_decode: combinational decode of one {main, side} light pair.
//   main_lights [2:0] in  : {R,Y,G} one-hot main road lights
//   side_lights [2:0] in  : {R,Y,G} one-hot side road lights
//   phase       [1:0] out : phase of the pair (0 when not legal)
//   legal             out : pair is one of the four legal phase patterns
module traffic_light_decode
  import traffic_pkg::*;
(
  input  logic [2:0] main_lights,
  input  logic [2:0] side_lights,
  output logic [1:0] phase,
  output logic       legal
);

  // Only the four controller phases are legal; everything else (all-red,
  // all-off, multi-hot) decodes as illegal.
  always_comb begin
    phase = PH_MG_SR;
    legal = 1'b0;
    case ({main_lights, side_lights})
      {GREEN, RED}: begin
        phase = PH_MG_SR;
        legal = 1'b1;
      end
      {YELLOW, RED}: begin
        phase = PH_MY_SR;
        legal = 1'b1;
      end
      {RED, GREEN}: begin
        phase = PH_MR_SG;
        legal = 1'b1;
      end
      {RED, YELLOW}: begin
        phase = PH_MR_SY;
        legal = 1'b1;
      end
      default: begin
        phase = PH_MG_SR;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of the traffic light controller
// outputs. Locks onto the four-phase sequence, checks phase order and exact
// dwell per phase, and reports faults and running statistics.
//   clk                in  : system clock, rising edge
//   reset_n            in  : synchronous active-low reset
//   main_lights  [2:0] in  : main road lights {R,Y,G}
//   side_lights  [2:0] in  : side road lights {R,Y,G}
//   clr_cnt            in  : synchronous clear of fault_cnt and cycle_cnt
//   phase        [1:0] out : locked phase
//   phase_valid        out : monitor is locked
//   fault              out : one-cycle pulse per detected fault
//   fault_code   [2:0] out : code of the most recent fault
//   fault_cnt    [7:0] out : saturating fault count
//   cycle_cnt    [7:0] out : wrapping count of completed 3->0 cycles while locked
module traffic_light_monitor
  import traffic_pkg::*;
#(
  parameter logic [7:0] MAIN_GREEN_TIME = 8'd100,
  parameter logic [7:0] YELLOW_TIME     = 8'd30,
  parameter logic [7:0] SIDE_GREEN_TIME = 8'd60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] main_lights,
  input  logic [2:0] side_lights,
  input  logic       clr_cnt,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_cnt,
  output logic [7:0] cycle_cnt
);

  mon_state_e state_r, state_nxt_s;
  logic [5:0] pat_r;
  logic [1:0] prev_phase_r;
  logic       prev_legal_r;
  logic [1:0] phase_r, phase_nxt_s;
  logic [8:0] dwell_r, dwell_nxt_s;
  logic       fault_r, fault_nxt_s;
  logic [2:0] fault_code_r, code_nxt_s;
  logic [7:0] fault_cnt_r, cycle_cnt_r;
  logic       cyc_inc_s;

  logic [5:0] cur_pat_s;
  logic [1:0] cur_phase_s;
  logic       cur_legal_s;
  logic       change_s;
  logic [1:0] prev_succ_s;
  logic [1:0] lock_succ_s;
  logic [8:0] exp_dwell_s;

  traffic_light_decode u_decode (
    .main_lights (main_lights),
    .side_lights (side_lights),
    .phase       (cur_phase_s),
    .legal       (cur_legal_s)
  );

  assign cur_pat_s   = {main_lights, side_lights};
  assign change_s    = (cur_pat_s != pat_r);
  // Successors wrap 3 -> 0 through the 2-bit add.
  assign prev_succ_s = prev_phase_r + 2'd1;
  assign lock_succ_s = phase_r + 2'd1;

  // Expected dwell of the locked phase: controller timer load plus one.
  always_comb begin
    case (phase_r)
      PH_MG_SR: exp_dwell_s = {1'b0, MAIN_GREEN_TIME} + 9'd1;
      PH_MY_SR: exp_dwell_s = {1'b0, YELLOW_TIME} + 9'd1;
      PH_MR_SG: exp_dwell_s = {1'b0, SIDE_GREEN_TIME} + 9'd1;
      PH_MR_SY: exp_dwell_s = {1'b0, YELLOW_TIME} + 9'd1;
      default:  exp_dwell_s = {1'b0, MAIN_GREEN_TIME} + 9'd1;
    endcase
  end

  // Acquire/lock FSM: next state, phase, dwell and fault decision.
  always_comb begin
    state_nxt_s = state_r;
    phase_nxt_s = phase_r;
    dwell_nxt_s = dwell_r;
    fault_nxt_s = 1'b0;
    code_nxt_s  = fault_code_r;
    cyc_inc_s   = 1'b0;
    case (state_r)
      ST_ACQUIRE: begin
        dwell_nxt_s = 9'd0;
        if (!cur_legal_s) begin
          // Only the entry into an illegal pattern is reported.
          if (change_s) begin
            fault_nxt_s = 1'b1;
            code_nxt_s  = FC_ILLEGAL;
          end else begin
            fault_nxt_s = 1'b0;
          end
        end else if (change_s && prev_legal_r && (cur_phase_s == prev_succ_s)) begin
          state_nxt_s = ST_LOCKED;
          phase_nxt_s = cur_phase_s;
          dwell_nxt_s = 9'd1;
        end else begin
          state_nxt_s = ST_ACQUIRE;
        end
      end
      ST_LOCKED: begin
        if (!cur_legal_s) begin
          fault_nxt_s = 1'b1;
          code_nxt_s  = FC_ILLEGAL;
          state_nxt_s = ST_ACQUIRE;
        end else if (change_s && (cur_phase_s != lock_succ_s)) begin
          fault_nxt_s = 1'b1;
          code_nxt_s  = FC_TRANSITION;
          state_nxt_s = ST_ACQUIRE;
        end else if (change_s) begin
          if (dwell_r < exp_dwell_s) begin
            fault_nxt_s = 1'b1;
            code_nxt_s  = FC_SHORT;
            state_nxt_s = ST_ACQUIRE;
          end else begin
            phase_nxt_s = cur_phase_s;
            dwell_nxt_s = 9'd1;
            cyc_inc_s   = (phase_r == PH_MR_SY);
          end
        end else if (dwell_r == exp_dwell_s) begin
          // Pattern held past its expected dwell: fire on the overstaying cycle.
          fault_nxt_s = 1'b1;
          code_nxt_s  = FC_LONG;
          state_nxt_s = ST_ACQUIRE;
        end else begin
          dwell_nxt_s = dwell_inc(dwell_r);
        end
      end
      default: begin
        state_nxt_s = ST_ACQUIRE;
        dwell_nxt_s = 9'd0;
      end
    endcase
  end

  // State, history and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r      <= ST_ACQUIRE;
      pat_r        <= 6'b000000;
      prev_phase_r <= 2'd0;
      prev_legal_r <= 1'b0;
      phase_r      <= 2'd0;
      dwell_r      <= 9'd0;
      fault_r      <= 1'b0;
      fault_code_r <= FC_NONE;
      fault_cnt_r  <= 8'd0;
      cycle_cnt_r  <= 8'd0;
    end else begin
      state_r      <= state_nxt_s;
      pat_r        <= cur_pat_s;
      prev_phase_r <= cur_phase_s;
      prev_legal_r <= cur_legal_s;
      phase_r      <= phase_nxt_s;
      dwell_r      <= dwell_nxt_s;
      fault_r      <= fault_nxt_s;
      fault_code_r <= code_nxt_s;
      // Clear takes precedence over a coincident increment.
      if (clr_cnt) begin
        fault_cnt_r <= 8'd0;
        cycle_cnt_r <= 8'd0;
      end else begin
        if (fault_nxt_s && (fault_cnt_r != 8'd255)) begin
          fault_cnt_r <= fault_cnt_r + 8'd1;
        end else begin
          fault_cnt_r <= fault_cnt_r;
        end
        if (cyc_inc_s) begin
          cycle_cnt_r <= cycle_cnt_r + 8'd1;
        end else begin
          cycle_cnt_r <= cycle_cnt_r;
        end
      end
    end
  end

  assign phase       = phase_r;
  assign phase_valid = (state_r == ST_LOCKED);
  assign fault       = fault_r;
  assign fault_code  = fault_code_r;
  assign fault_cnt   = fault_cnt_r;
  assign cycle_cnt   = cycle_cnt_r;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor. Inputs change just after a
// rising edge; outputs are sampled 1 time unit after the next rising edge,
// when they reflect the inputs of the cycle just ended.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       clk;
  logic       reset_n;
  logic [2:0] main_lights;
  logic [2:0] side_lights;
  logic       clr_cnt;
  logic [1:0] phase;
  logic       phase_valid;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] fault_cnt;
  logic [7:0] cycle_cnt;

  int checks;
  int errors;
  int pulse_cnt;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .main_lights (main_lights),
    .side_lights (side_lights),
    .clr_cnt     (clr_cnt),
    .phase       (phase),
    .phase_valid (phase_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .fault_cnt   (fault_cnt),
    .cycle_cnt   (cycle_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle with the given lights; tallies fault pulses seen.
  task automatic step(input logic [2:0] m, input logic [2:0] s);
    main_lights = m;
    side_lights = s;
    @(posedge clk);
    #1;
    if (fault === 1'b1) pulse_cnt++;
  endtask

  task automatic run(input logic [2:0] m, input logic [2:0] s, input int n);
    for (int i = 0; i < n; i++) step(m, s);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    step(G, R);
    step(G, R);
    checks++; if (phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", phase_valid); end
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL reset_fault got %0b want 0", fault); end
    checks++; if (fault_code !== 3'd0) begin errors++; $display("FAIL reset_code got %0d want 0", fault_code); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL reset_fault_cnt got %0d want 0", fault_cnt); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("FAIL reset_cycle_cnt got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_normal;
    reset_n = 1'b1;
    pulse_cnt = 0;
    run(G, R, 101);
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL prelock_valid got %0b want 0", phase_valid); end
    step(Y, R);
    checks++; if (phase_valid !== 1'b1) begin errors++; $display("FAIL lock_valid got %0b want 1", phase_valid); end
    checks++; if (phase !== 2'd1) begin errors++; $display("FAIL lock_phase got %0d want 1", phase); end
    run(Y, R, 30);
    run(R, G, 61);
    run(R, Y, 31);
    for (int k = 0; k < 3; k++) begin
      run(G, R, 101);
      run(Y, R, 31);
      run(R, G, 61);
      run(R, Y, 31);
    end
    step(G, R);
    checks++; if (cycle_cnt !== 8'd4) begin errors++; $display("FAIL normal_cycle_cnt got %0d want 4", cycle_cnt); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL normal_fault_cnt got %0d want 0", fault_cnt); end
    checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL normal_pulses got %0d want 0", pulse_cnt); end
    checks++; if (phase !== 2'd0 || phase_valid !== 1'b1) begin errors++; $display("FAIL normal_end got phase %0d valid %0b want 0/1", phase, phase_valid); end
  endtask

  task automatic test_dwell_short;
    run(G, R, 100);
    run(Y, R, 31);
    run(R, G, 40);
    step(R, Y);
    checks++; if (fault !== 1'b1) begin errors++; $display("FAIL short_fault got %0b want 1", fault); end
    checks++; if (fault_code !== 3'd3) begin errors++; $display("FAIL short_code got %0d want 3", fault_code); end
    checks++; if (phase_valid !== 1'b0) begin errors++; $display("FAIL short_valid got %0b want 0", phase_valid); end
    checks++; if (fault_cnt !== 8'd1) begin errors++; $display("FAIL short_fault_cnt got %0d want 1", fault_cnt); end
    step(R, Y);
    checks++; if (fault !== 1'b0) begin errors++; $display("FAIL short_pulse_width got %0b want 0", fault); end
  endtask

  task automatic test_dwell_long;
    step(G, R);
    checks++; if (phase_valid !== 1'b1 || phase !== 2'd0) begin errors++; $display("FAIL long_relock got valid %0b phase %0d want 1/0", phase_valid, phase); end
    run(G, R, 100);
    run(Y, R, 31);
    checks++; if (fault !== 1'b0 || phase_valid !== 1'b1) begin errors++; $display("FAIL long_at_limit got fault %0b valid %0b want 0/1", fault, phase_valid); end
    step(Y, R);
    checks++; if (fault !== 1'b1 || fault_code !== 3'd4) begin errors++; $display("FAIL long_fault got fault %0b code %0d want 1/4", fault, fault_code); end
    checks++; if (phase_valid !== 1'b0 || fault_cnt !== 8'd2) begin errors++; $display("FAIL long_state got valid %0b cnt %0d want 0/2", phase_valid, fault_cnt); end
    step(R, G);
    checks++; if (phase_valid !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL long_relock2 got valid %0b phase %0d want 1/2", phase_valid, phase); end
  endtask

  task automatic test_illegal;
    pulse_cnt = 0;
    run(3'b110, 3'b100, 5);
    checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL illegal_pulses got %0d want 1", pulse_cnt); end
    checks++; if (fault_code !== 3'd1 || phase_valid !== 1'b0) begin errors++; $display("FAIL illegal_code got code %0d valid %0b want 1/0", fault_code, phase_valid); end
    checks++; if (fault_cnt !== 8'd3) begin errors++; $display("FAIL illegal_fault_cnt got %0d want 3", fault_cnt); end
    step(R, Y);
    step(G, R);
    checks++; if (phase_valid !== 1'b1 || phase !== 2'd0) begin errors++; $display("FAIL illegal_relock got valid %0b phase %0d want 1/0", phase_valid, phase); end
    step(R, G);
    checks++; if (fault !== 1'b1 || fault_code !== 3'd2) begin errors++; $display("FAIL jump_fault got fault %0b code %0d want 1/2", fault, fault_code); end
    checks++; if (phase_valid !== 1'b0 || fault_cnt !== 8'd4) begin errors++; $display("FAIL jump_state got valid %0b cnt %0d want 0/4", phase_valid, fault_cnt); end
  endtask

  task automatic test_saturate;
    pulse_cnt = 0;
    for (int i = 0; i < 150; i++) begin
      step(3'b110, 3'b100);
      step(3'b111, 3'b111);
    end
    checks++; if (pulse_cnt !== 300) begin errors++; $display("FAIL sat_pulses got %0d want 300", pulse_cnt); end
    checks++; if (fault_cnt !== 8'd255) begin errors++; $display("FAIL sat_fault_cnt got %0d want 255", fault_cnt); end
    checks++; if (fault_code !== 3'd1) begin errors++; $display("FAIL sat_code got %0d want 1", fault_code); end
    step(R, Y);
    step(G, R);
    checks++; if (phase_valid !== 1'b1) begin errors++; $display("FAIL sat_relock got %0b want 1", phase_valid); end
    clr_cnt = 1'b1;
    step(R, G);
    clr_cnt = 1'b0;
    checks++; if (fault !== 1'b1 || fault_code !== 3'd2) begin errors++; $display("FAIL clr_fault got fault %0b code %0d want 1/2", fault, fault_code); end
    checks++; if (fault_cnt !== 8'd0) begin errors++; $display("FAIL clr_fault_cnt got %0d want 0", fault_cnt); end
    checks++; if (cycle_cnt !== 8'd0) begin errors++; $display("FAIL clr_cycle_cnt got %0d want 0", cycle_cnt); end
  endtask

  task automatic test_reset_mid;
    step(Y, R);
    step(R, G);
    checks++; if (phase_valid !== 1'b1 || phase !== 2'd2) begin errors++; $display("FAIL mid_lock got valid %0b phase %0d want 1/2", phase_valid, phase); end
    step(3'b110, 3'b100);
    step(R, G);
    run(R, G, 10);
    reset_n = 1'b0;
    step(R, G);
    reset_n = 1'b1;
    checks++; if (phase !== 2'd0 || phase_valid !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL mid_reset got phase %0d valid %0b fault %0b want 0/0/0", phase, phase_valid, fault); end
    checks++; if (fault_code !== 3'd0 || fault_cnt !== 8'd0 || cycle_cnt !== 8'd0) begin errors++; $display("FAIL mid_reset_cnt got code %0d fcnt %0d ccnt %0d want 0/0/0", fault_code, fault_cnt, cycle_cnt); end
    run(R, G, 20);
    checks++; if (phase_valid !== 1'b0 || fault_cnt !== 8'd0) begin errors++; $display("FAIL mid_prelock got valid %0b cnt %0d want 0/0", phase_valid, fault_cnt); end
    step(R, Y);
    checks++; if (phase_valid !== 1'b1 || phase !== 2'd3 || fault !== 1'b0) begin errors++; $display("FAIL mid_relock got valid %0b phase %0d fault %0b want 1/3/0", phase_valid, phase, fault); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    pulse_cnt = 0;
    reset_n = 1'b0;
    clr_cnt = 1'b0;
    main_lights = G;
    side_lights = R;
    test_reset;
    test_normal;
    test_dwell_short;
    test_dwell_long;
    test_illegal;
    test_saturate;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
